// File: rtl/trafficlight_ew.sv
// East-West traffic light: holds red while North-South runs, then left/green/yellow.
// Emergency forces all-red with a clearance interval; a sticky monitor flags go/go conflicts.
module trafficlight_ew #(
    parameter int LEFT_CYCLES   = 5,
    parameter int GREEN_CYCLES  = 10,
    parameter int YELLOW_CYCLES = 3,
    parameter int RED_CYCLES    = 18,
    parameter int CLEAR_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    input  logic       ns_go,
    output logic [3:0] out,
    output logic       allstop,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_RED,
        S_LEFT,
        S_GREEN,
        S_YELLOW,
        S_ALLSTOP,
        S_CLEAR
    } state_t;

    localparam logic [4:0] RED_LAST    = 5'(RED_CYCLES - 1);
    localparam logic [4:0] LEFT_LAST   = 5'(LEFT_CYCLES - 1);
    localparam logic [4:0] GREEN_LAST  = 5'(GREEN_CYCLES - 1);
    localparam logic [4:0] YELLOW_LAST = 5'(YELLOW_CYCLES - 1);
    localparam int         CLR_LAST_I  = (CLEAR_CYCLES > 0) ? CLEAR_CYCLES - 1 : 0;
    localparam logic [4:0] CLR_LAST    = 5'(CLR_LAST_I);
    localparam logic [3:0] O_RED       = 4'b0001;

    generate
        if (RED_CYCLES < 1 || LEFT_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1)
            $error("trafficlight_ew: phase lengths must be at least 1");
    endgenerate

    state_t     state, saved_state;
    logic [4:0] count, saved_count, clr_count;

    function automatic logic [4:0] last_of(input state_t s);
        case (s)
            S_LEFT:   return LEFT_LAST;
            S_GREEN:  return GREEN_LAST;
            S_YELLOW: return YELLOW_LAST;
            default:  return RED_LAST;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            S_RED:   return S_LEFT;
            S_LEFT:  return S_GREEN;
            S_GREEN: return S_YELLOW;
            default: return S_RED;
        endcase
    endfunction

    function automatic logic [3:0] enc(input state_t s);
        case (s)
            S_LEFT:   return 4'b1001;
            S_GREEN:  return 4'b0100;
            S_YELLOW: return 4'b0010;
            default:  return O_RED;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RED;
            count       <= '0;
            clr_count   <= '0;
            saved_state <= S_RED;
            saved_count <= '0;
            out         <= O_RED;
            allstop     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // Monitor looks at what is actually being displayed this cycle
            if ((out[3] | out[2]) & ns_go)
                fault <= 1'b1;

            case (state)
                S_RED, S_LEFT, S_GREEN, S_YELLOW: begin
                    if (emergency) begin
                        // Pre-wrap context is saved; the pending wrap is dropped
                        saved_state <= state;
                        saved_count <= count;
                        state       <= S_ALLSTOP;
                        out         <= O_RED;
                        allstop     <= 1'b1;
                    end else if (count == last_of(state)) begin
                        state <= next_of(state);
                        count <= '0;
                        out   <= enc(next_of(state));
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                S_ALLSTOP: begin
                    if (!emergency) begin
                        if (CLEAR_CYCLES > 0) begin
                            state     <= S_CLEAR;
                            clr_count <= '0;
                        end else begin
                            state   <= saved_state;
                            count   <= saved_count;
                            out     <= enc(saved_state);
                            allstop <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    if (emergency) begin
                        state <= S_ALLSTOP;
                    end else if (clr_count == CLR_LAST) begin
                        state   <= saved_state;
                        count   <= saved_count;
                        out     <= enc(saved_state);
                        allstop <= 1'b0;
                    end else begin
                        clr_count <= clr_count + 5'd1;
                    end
                end
                default: begin
                    state   <= S_RED;
                    count   <= '0;
                    out     <= O_RED;
                    allstop <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/trafficlight_ew.md
# trafficlight_ew

East-West counterpart of the North-South traffic light controller. It holds red while North-South runs its left, green and yellow phases, then runs its own left-turn, green and yellow phases. An emergency request overrides it to all-red, with a post-emergency clearance interval. It also includes a sticky safety monitor that flags any cycle in which both directions show a go indication.

## Interface
- LEFT_CYCLES, 5, cycles of left turn + red (1..31)
- GREEN_CYCLES, 10, cycles of green (1..31)
- YELLOW_CYCLES, 3, cycles of yellow (1..31)
- RED_CYCLES, 18, cycles of red; must equal the NS left+green+yellow total (1..31)
- CLEAR_CYCLES, 1, all-red cycles after emergency release (0..31)
- clk  input  1  clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- emergency  input  1  emergency vehicle present; sampled on posedge clk
- ns_go  input  1  NS light showing left or green (NS out[3] | out[2])
- out  output  4  [3] left, [2] green, [1] yellow, [0] red
- allstop  output  1  high while in ALLSTOP or CLEAR
- fault  output  1  sticky conflict flag

## Operation
- States: RED, LEFT, GREEN, YELLOW, ALLSTOP, CLEAR.
- One 5-bit phase counter. A phase of N cycles counts 0..N-1. At count N-1 the block moves to the next phase with count 0.
- Normal cycle: RED → LEFT → GREEN → YELLOW → RED. Period is RED+LEFT+GREEN+YELLOW cycles (36 with defaults).
- out encoding:
  - RED 0001, LEFT 1001, GREEN 0100, YELLOW 0010.
  - ALLSTOP and CLEAR 0001.
- Emergency entry:
  - Condition: emergency=1 at an edge while in RED, LEFT, GREEN or YELLOW.
  - Actions: saved_state ← current state; saved_count ← current count (not advanced); state ← ALLSTOP.
- ALLSTOP: stays while emergency=1; the counter is frozen.
  - emergency=0 and CLEAR_CYCLES>0 → CLEAR, clear counter 0.
  - emergency=0 and CLEAR_CYCLES=0 → saved_state with saved_count.
- CLEAR: lasts CLEAR_CYCLES cycles, then saved_state resumes with saved_count. The phase completes its remaining cycles.
  - emergency=1 during CLEAR → ALLSTOP; saved_state and saved_count are unchanged.
- fault: set when (out[3]|out[2]) & ns_go in a cycle. It stays set until reset; it is never cleared by anything else.
- Reset: state RED, count 0, clear counter 0, saved_state RED, saved_count 0, out 0001, allstop 0, fault 0.
  - Reset dominates emergency and ns_go in the same cycle.

## Timing
- out and allstop are registered and update on the same edge as the state register. There are no combinational paths from inputs to outputs.
- Emergency latency: emergency sampled high at edge k gives out=0001 and allstop=1 from edge k.
- Release latency: emergency sampled low at edge m puts CLEAR from m through m+CLEAR_CYCLES-1. The saved phase resumes at edge m+CLEAR_CYCLES.
- fault latency: a conflict in the cycle ending at edge k gives fault=1 from edge k onward.
- Emergency at the final count of a phase: the block resumes at that final count, shows one more cycle of the phase, then advances.
- Emergency in the same cycle as the phase wrap: the pre-wrap state and count are saved; the wrap does not occur.
- Reset asserted mid-ALLSTOP or mid-CLEAR: the saved context is discarded. If emergency is high in the first cycle after reset deasserts, the block enters ALLSTOP saving RED/0.
- Out-of-range parameter values are unsupported. Elaboration fails if RED_CYCLES or any phase is 0.

## Test plan
- Default parameters, no emergency, after reset (cycle 0):
  - out=0001 cycles 0-17, 1001 cycles 18-22, 0100 cycles 23-32, 0010 cycles 33-35, 0001 from cycle 36.
  - The pattern repeats every 36 cycles; allstop=0 and fault=0 throughout.
- Emergency high for cycles 27-29 (GREEN, count 4):
  - out=0001 and allstop=1 for cycles 27-30.
  - GREEN at count 4 resumes at cycle 31, out=0100 cycles 31-36, 0010 cycles 37-39, RED from cycle 40.
- Emergency one cycle at cycle 35 (YELLOW, count 2):
  - out=0001 cycles 35-36 (ALLSTOP, CLEAR), 0010 at cycle 37, RED count 0 at cycle 38.
- Emergency at cycles 20 and 22 with a gap at 21 (LEFT, count 2):
  - Cycle 21 is CLEAR, cycle 22 is ALLSTOP again, cycle 23 is CLEAR.
  - LEFT resumes at count 2 at cycle 24, out=1001 cycles 24-26, GREEN from cycle 27.
- ns_go=1 at cycle 25 (EW green): fault=1 from cycle 26, held through cycle 100. ns_go=1 during cycles 0-17 (EW red) leaves fault=0.
- reset=1 at cycle 28 while emergency=1 and in ALLSTOP:
  - Cycle 29: out=0001, allstop=0, fault=0.
  - emergency=0 from cycle 29 onward: LEFT begins at cycle 47.
